// File: rtl/wb_sram_bist_master.sv
// wb_sram_bist_master
//   Wishbone classic-cycle master that runs a four-phase march test
//   (W0 -> R0 -> W1 -> R1) over a window of DEPTH 32-bit SRAM words
//   starting at byte address BASE_ADR. Pattern P(i) = {~i16, i16}.
//   Stops at the first read mismatch and reports its index and data.
//
//   Optional feature macro: BIST_TIMEOUT_EN
//     defined   : an ack watchdog of TIMEOUT cycles ends the test with timeout_o=1.
//     undefined : the master waits forever for ack; timeout_o stays 0.
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   start_i                   one-cycle start request (sampled in IDLE/DONE)
//   busy_o, done_o, pass_o    status (done_o sticky, pass_o valid when done_o)
//   fail_idx_o, fail_dat_o    index / read data of first failure
//   timeout_o                 failure was an ack timeout
//   wbm_*                     Wishbone master port (all outputs registered)
module wb_sram_bist_master #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned DEPTH    = 4096,
  parameter int unsigned IW       = 12,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          pass_o,
  output logic [IW-1:0] fail_idx_o,
  output logic [31:0]   fail_dat_o,
  output logic          timeout_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [31:0]   wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic [31:0]   wbm_dat_i,
  input  logic          wbm_ack_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W0,
    S_R0,
    S_W1,
    S_R1,
    S_DONE
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  state_t        state;
  logic [IW-1:0] idx;

  logic          is_write;
  logic          is_read;
  logic [31:0]   cur_pat;
  logic [31:0]   wr_dat;
  logic [31:0]   exp_rd;
  logic [31:0]   cur_adr;

  function automatic logic [31:0] pat(input logic [IW-1:0] i);
    logic [15:0] i16;
    i16 = 16'(i);
    return {~i16, i16};
  endfunction

  always_comb begin
    is_write = (state == S_W0) || (state == S_W1);
    is_read  = (state == S_R0) || (state == S_R1);
    cur_pat  = pat(idx);
    exp_rd   = (state == S_R0) ? cur_pat : ~cur_pat;
    wr_dat   = '0;
    if (state == S_W0) wr_dat = cur_pat;
    if (state == S_W1) wr_dat = ~cur_pat;
    cur_adr  = BASE_ADR + (32'(idx) << 2);
  end

`ifdef BIST_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] tcnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      idx        <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      pass_o     <= 1'b0;
      fail_idx_o <= '0;
      fail_dat_o <= '0;
      timeout_o  <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
`ifdef BIST_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            // First W0 transfer (idx 0) is launched on the start edge itself.
            state      <= S_W0;
            idx        <= '0;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            fail_idx_o <= '0;
            fail_dat_o <= '0;
            timeout_o  <= 1'b0;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            wbm_we_o   <= 1'b1;
            wbm_sel_o  <= '1;
            wbm_adr_o  <= BASE_ADR;
            wbm_dat_o  <= pat('0);
`ifdef BIST_TIMEOUT_EN
            tcnt       <= '0;
`endif
          end
        end

        default: begin
          if (!wbm_stb_o) begin
            // Gap cycle after an ack: launch the transfer for the (already
            // advanced) state/idx.
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= is_write;
            wbm_sel_o <= '1;
            wbm_adr_o <= cur_adr;
            wbm_dat_o <= wr_dat;
`ifdef BIST_TIMEOUT_EN
            tcnt      <= '0;
`endif
          end else if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            if (is_read && (wbm_dat_i != exp_rd)) begin
              fail_idx_o <= idx;
              fail_dat_o <= wbm_dat_i;
              pass_o     <= 1'b0;
              state      <= S_DONE;
              busy_o     <= 1'b0;
              done_o     <= 1'b1;
            end else if (idx == LAST_IDX) begin
              idx <= '0;
              case (state)
                S_W0:    state <= S_R0;
                S_R0:    state <= S_W1;
                S_W1:    state <= S_R1;
                default: begin
                  state  <= S_DONE;
                  pass_o <= 1'b1;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                end
              endcase
            end else begin
              idx <= idx + 1'b1;
            end
          end
`ifdef BIST_TIMEOUT_EN
          // Ack is checked first, so an ack on the limit cycle wins.
          else if (tcnt == TO_LAST) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_we_o   <= 1'b0;
            wbm_sel_o  <= '0;
            timeout_o  <= 1'b1;
            pass_o     <= 1'b0;
            fail_idx_o <= idx;
            fail_dat_o <= '0;
            state      <= S_DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
          end else begin
            tcnt <= tcnt + 32'd1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_bist_master.sv
module tb_wb_sram_bist_master;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IW    = 4;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          start_i;
  logic          busy_o, done_o, pass_o, timeout_o;
  logic [IW-1:0] fail_idx_o;
  logic [31:0]   fail_dat_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o, wbm_dat_o;
  logic [31:0]   wbm_dat_i;
  logic          wbm_ack_i;

  wb_sram_bist_master #(
    .BASE_ADR(BASE),
    .DEPTH   (DEPTH),
    .IW      (IW),
    .TIMEOUT (8)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .pass_o    (pass_o),
    .fail_idx_o(fail_idx_o),
    .fail_dat_o(fail_dat_o),
    .timeout_o (timeout_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SRAM slave model ----------------
  logic [31:0] mem [DEPTH];
  logic        ack_r, spur_r;
  bit          rand_wait = 0, spur_en = 0, stuck_en = 0, noack_en = 0;
  int unsigned wait_left;

  // Spurious acks appear only in cycles where cyc is low.
  assign wbm_ack_i = ack_r | (spur_en & spur_r & ~wbm_cyc_o);

  always @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r     <= 1'b0;
      spur_r    <= 1'b0;
      wait_left <= 0;
      wbm_dat_i <= '0;
    end else begin
      spur_r <= 1'($urandom_range(0, 1));
      ack_r  <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !ack_r &&
          !(noack_en && wbm_we_o && wbm_adr_o == BASE + 32'd12)) begin
        if (wait_left != 0) begin
          wait_left <= wait_left - 1;
        end else begin
          ack_r <= 1'b1;
          if (wbm_we_o) mem[wbm_adr_o[IW+1:2]] <= wbm_dat_o;
          wbm_dat_i <= (stuck_en && wbm_adr_o[IW+1:2] == IW'(5)) ? 32'h0 : mem[wbm_adr_o[IW+1:2]];
          wait_left <= rand_wait ? $urandom_range(0, 5) : 0;
        end
      end
    end
  end

  // ---------------- scoreboard + bus monitor ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  xfer_t       exp_q[$];
  int unsigned xfers = 0;
  int unsigned stb_run = 0, last_run = 0;
  logic [31:0] lat_adr, lat_dat;
  logic        lat_we;

  function automatic logic [31:0] pat(input int unsigned i);
    logic [15:0] v;
    v = 16'(i);
    return {~v, v};
  endfunction

  // phase 0..3 = W0, R0, W1, R1; pushes transfers for idx 0..n-1
  task automatic push_phase(input int unsigned phase, input int unsigned n);
    xfer_t x;
    for (int unsigned i = 0; i < n; i++) begin
      x.adr = BASE + 32'(4 * i);
      x.we  = (phase == 0 || phase == 2);
      x.dat = (phase == 0) ? pat(i) : (phase == 2) ? ~pat(i) : 32'h0;
      exp_q.push_back(x);
    end
  endtask

  task automatic push_full();
    for (int unsigned p = 0; p < 4; p++) push_phase(p, DEPTH);
  endtask

  always @(negedge wb_clk_i) begin
    xfer_t e;
    if (wbm_stb_o) begin
      if (stb_run == 0) begin
        lat_adr = wbm_adr_o;
        lat_dat = wbm_dat_o;
        lat_we  = wbm_we_o;
      end else begin
        check("stable_adr", 65'(wbm_adr_o), 65'(lat_adr));
        check("stable_dat", 65'(wbm_dat_o), 65'(lat_dat));
        check("stable_we",  65'(wbm_we_o),  65'(lat_we));
      end
      check("sel_f", 65'(wbm_sel_o), 65'(4'hF));
      check("cyc_with_stb", 65'(wbm_cyc_o), 65'(1'b1));
      stb_run++;
      if (wbm_ack_i) begin
        xfers++;
        check("sb_have_expected", 65'(exp_q.size() != 0), 65'(1'b1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_xfer", {wbm_we_o, wbm_adr_o, wbm_dat_o}, {e.we, e.adr, e.dat});
        end
      end
    end else begin
      if (stb_run != 0) last_run = stb_run;
      stb_run = 0;
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(negedge wb_clk_i) start_i = 1'b1;
    @(negedge wb_clk_i) start_i = 1'b0;
  endtask

  task automatic wait_done(output int unsigned n);
    n = 0;
    while (done_o !== 1'b1 && n < 20000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("done_within_bound", 65'(done_o), 65'(1'b1));
    @(negedge wb_clk_i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned n;

  initial begin
    wb_rst_i = 1'b1;
    start_i  = 1'b0;
    repeat (3) @(negedge wb_clk_i);

    // reset state
    check("rst_ctl", 65'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, busy_o, done_o, pass_o, timeout_o}), 65'(0));
    check("rst_adr", 65'(wbm_adr_o), 65'(0));
    check("rst_dat", 65'(wbm_dat_o), 65'(0));
    check("rst_fail", 65'({fail_idx_o, fail_dat_o}), 65'(0));
    wb_rst_i = 1'b0;

    // 1: full passing run, 1-cycle slave
    push_full();
    xfers = 0;
    pulse_start();
    check("first_xfer", {wbm_we_o, wbm_adr_o, wbm_dat_o}, {1'b1, 32'h3000_0000, 32'hFFFF_0000});
    check("busy_running", 65'(busy_o), 65'(1'b1));
    wait_done(n);
    check("run_cycles", 65'(n), 65'(191));
    check("xfer_count", 65'(xfers), 65'(64));
    check("pass_status", 65'({done_o, pass_o, busy_o, wbm_cyc_o, timeout_o}), 65'(5'b11000));
    check("sb_empty", 65'(exp_q.size()), 65'(0));

    // 2: word 5 stuck at zero, fails in R0
    stuck_en = 1;
    push_phase(0, DEPTH);
    push_phase(1, 6);
    xfers = 0;
    pulse_start();
    wait_done(n);
    check("stuck_pass", 65'(pass_o), 65'(1'b0));
    check("stuck_idx", 65'(fail_idx_o), 65'(5));
    check("stuck_dat", 65'(fail_dat_o), 65'(32'h0));
    check("stuck_timeout", 65'(timeout_o), 65'(1'b0));
    check("stuck_xfers", 65'(xfers), 65'(DEPTH + 6));
    check("stuck_sb_empty", 65'(exp_q.size()), 65'(0));

    // 3: start in DONE clears results; start while busy is ignored
    stuck_en = 0;
    push_full();
    xfers = 0;
    pulse_start();
    check("restart_clear", 65'({done_o, pass_o, busy_o, fail_idx_o, fail_dat_o}), {28'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'h0});
    repeat (50) @(negedge wb_clk_i);
    pulse_start();
    repeat (30) @(negedge wb_clk_i);
    pulse_start();
    wait_done(n);
    check("busy_start_xfers", 65'(xfers), 65'(64));
    check("busy_start_pass", 65'(pass_o), 65'(1'b1));
    check("busy_start_sb_empty", 65'(exp_q.size()), 65'(0));

    // 4: asynchronous reset mid-W1
    push_full();
    xfers = 0;
    pulse_start();
    n = 0;
    while ((xfers < 40 || wbm_stb_o !== 1'b1) && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    check("reach_w1", 65'(xfers >= 40 && wbm_stb_o === 1'b1), 65'(1'b1));
    #2 wb_rst_i = 1'b1;
    #1 check("async_rst", 65'({wbm_cyc_o, wbm_stb_o, done_o, busy_o}), 65'(0));
    @(negedge wb_clk_i) wb_rst_i = 1'b0;
    exp_q.delete();
    push_full();
    xfers = 0;
    pulse_start();
    wait_done(n);
    check("post_rst_pass", 65'(pass_o), 65'(1'b1));
    check("post_rst_xfers", 65'(xfers), 65'(64));

    // 5: random wait states and spurious acks while cyc is low
    rand_wait = 1;
    spur_en   = 1;
    repeat (12) @(negedge wb_clk_i);
    check("spur_idle", 65'({done_o, pass_o, busy_o, wbm_cyc_o}), 65'(4'b1100));
    push_full();
    xfers = 0;
    pulse_start();
    wait_done(n);
    check("rand_pass", 65'(pass_o), 65'(1'b1));
    check("rand_xfers", 65'(xfers), 65'(64));
    check("rand_sb_empty", 65'(exp_q.size()), 65'(0));
    rand_wait = 0;
    spur_en   = 0;

`ifdef BIST_TIMEOUT_EN
    // 6: slave never acks idx 3 in W0
    noack_en = 1;
    push_phase(0, 3);
    xfers = 0;
    pulse_start();
    wait_done(n);
    check("to_flag", 65'(timeout_o), 65'(1'b1));
    check("to_pass", 65'(pass_o), 65'(1'b0));
    check("to_idx", 65'(fail_idx_o), 65'(3));
    check("to_dat", 65'(fail_dat_o), 65'(0));
    check("to_cyc", 65'(wbm_cyc_o), 65'(1'b0));
    check("to_stb_cycles", 65'(last_run), 65'(8));
    check("to_xfers", 65'(xfers), 65'(3));
    noack_en = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_sram_bist_master.md
Name: wb_sram_bist_master

Overview:
- Wishbone classic-cycle master that drives the 4096x32 SRAM's Wishbone slave port and runs a four-phase march self-test over a configurable window.
- Sits beside the SRAM in the user area; the management core (or LA pins) starts it, and it reports pass/fail plus the first failing word.
- Used for bring-up and production screening of the SRAM macro without firmware involvement.

Parameters:
- BASE_ADR, 32'h3000_0000, byte address of word 0 of the test window.
- DEPTH, 4096, number of 32-bit words tested; power of two, 2..4096.
- IW, 12, index width; must satisfy 2**IW == DEPTH.
- TIMEOUT, 255, ack watchdog limit in cycles; used only with BIST_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  clock; the only clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle start request.
- busy_o  out  1  test in progress.
- done_o  out  1  sticky: test finished.
- pass_o  out  1  valid when done_o=1; 1 means no mismatch and no timeout.
- fail_idx_o  out  IW  word index of the first failure.
- fail_dat_o  out  32  data read at the first failure.
- timeout_o  out  1  failure was an ack timeout.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects; always 4'hF while stb is high.
- wbm_adr_o  out  32  byte address, BASE_ADR + 4*idx.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  slave acknowledge.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0, including wbm_adr_o and wbm_dat_o. State = IDLE, idx = 0.
- Reset is asynchronous: asserting it mid-test drops cyc/stb immediately, with no bus-cycle completion.
- Pattern: P(i) = {~i16, i16}, where i16 is idx zero-extended to 16 bits. Example: P(5) = 32'hFFFA_0005.
- States: IDLE -> W0 -> R0 -> W1 -> R1 -> DONE.
  - W0 writes P(i) to every word.
  - R0 reads every word and checks it against P(i).
  - W1 writes ~P(i) to every word.
  - R1 reads every word and checks it against ~P(i).
  - idx runs 0..DEPTH-1 in each phase and wraps to 0 on each phase change.
- Start:
  - start_i is sampled only in IDLE or DONE. Sampling it clears done_o, pass_o, fail_idx_o, fail_dat_o and timeout_o, and enters W0.
  - start_i is ignored while busy_o=1.
  - busy_o = 1 in W0 through R1.
- Bus handshake, per transfer:
  - Assert cyc=stb=1 with adr, we, sel and dat stable; hold until wbm_ack_i is sampled high.
  - On the edge where ack is sampled, drop cyc/stb for exactly one cycle, then issue the next transfer.
  - With a 1-cycle-latency slave ack, a transfer takes 3 cycles.
  - wbm_ack_i while cyc=0 is ignored.
- Read check: on the ack edge in R0 or R1, compare wbm_dat_i with the expected value.
  - On mismatch: capture fail_idx_o = idx and fail_dat_o = wbm_dat_i, set pass_o = 0, go to DONE. The test stops at the first error.
- Completion: ack of idx = DEPTH-1 in R1 with a matching value enters DONE with pass_o = 1.
- DONE: done_o = 1, busy_o = 0, cyc = stb = 0. Results hold until the next start or reset.
- wbm_we_o = 1 in W0/W1 and 0 in R0/R1. wbm_dat_o is don't-care during reads and is driven 0.

Optional Feature:
- BIST_TIMEOUT_EN defined:
  - A counter runs while stb=1 and resets on each new transfer.
  - If TIMEOUT cycles pass with no ack: drop cyc/stb, set timeout_o = 1, pass_o = 0, fail_idx_o = idx, fail_dat_o = 0, and enter DONE.
  - An ack arriving on the exact cycle the limit is reached wins; no timeout is flagged.
- BIST_TIMEOUT_EN undefined: the master waits forever for ack, and timeout_o is tied to 0.

Test Plan:
- DEPTH=16, model SRAM with 1-cycle ack, pulse start:
  - 64 transfers, each 3 cycles long.
  - First write is adr 3000_0000, dat FFFF_0000.
  - Then done_o=1, pass_o=1, busy_o=0.
- Same setup with word 5 stuck at 32'h0 in the model:
  - done_o=1, pass_o=0, fail_idx_o=5, fail_dat_o=0000_0000, stopping during R0.
  - No transfers with idx>5 in R0.
- Assert wb_rst_i mid-W1:
  - cyc/stb/done/busy go low in the same cycle, without waiting for a clock edge.
  - A subsequent start runs the full test to pass.
- Pulse start_i while busy:
  - Ignored; the transfer count stays 64.
  - A start in DONE clears the results and reruns the test.
- BIST_TIMEOUT_EN, TIMEOUT=8, slave never acks idx 3 in W0:
  - After 8 stb cycles: timeout_o=1, pass_o=0, fail_idx_o=3, cyc=0.
- Slave with random 0..5 wait states plus spurious ack while cyc=0:
  - Test still passes.
  - wbm_sel_o=F and adr/dat stable throughout every stb-high interval.
